mem_stage: RTL and testbench
============================

# mem_stage

Memory-access stage of the 8-bit pipeline, directly downstream of the execute stage. Consumes the execute stage's registered outputs (ALU result, jump target, store operand, zero flag, control bits), performs data-RAM loads and stores with a configurable read latency, resolves jumps and conditional jumps, and registers the write-back bundle. Asserts a stall back to upstream while a multi-cycle load is in flight.

## Interface
- `ADDR_BITS`, 5: data RAM address width; depth is 2^ADDR_BITS bytes.
- `RD_LAT`, 1: load wait cycles, 0–7; a load occupies RD_LAT+1 cycles.

- `clock`  in  1  rising-edge clock.
- `reset`  in  1  synchronous, active-high reset.
- `WRMem`  in  1  register write-back enable.
- `WMMem`  in  1  store to data RAM.
- `RMMem`  in  1  load from data RAM.
- `NEQMem`  in  1  conditional jump sense: 1 = jump on not-zero, 0 = jump on zero.
- `JMem`  in  1  unconditional jump.
- `JCMem`  in  1  conditional jump.
- `zeroIn`  in  1  ALU zero flag.
- `acIn`  in  8  ALU result: RAM address for loads and stores, write-back value otherwise.
- `jumpIn`  in  8  jump target.
- `rsIn`  in  8  store data.
- `stall`  out  1  combinational; upstream holds all inputs while high.
- `wbWR`  out  1  registered write-back enable.
- `wbData`  out  8  registered write-back value.
- `pcTaken`  out  1  registered one-cycle jump-taken pulse.
- `pcTarget`  out  8  registered jump target.
- `outPort`  out  8  registered output port; present only with `MEM_IO_EN`.

## Operation
- **Addressing:** the RAM index is `acIn[ADDR_BITS-1:0]`. Upper bits are ignored, so addresses wrap.
- **FSM states:** IDLE and WAIT. The wait counter `cnt` is 3 bits wide.
- **IDLE, no load:**
  - Register `wbWR<=WRMem` and `wbData<=acIn`.
  - If `WMMem` is set, write `RAM[addr]<=rsIn` at the same edge.
- **IDLE, load with RD_LAT=0:** register `wbData<=RAM[addr]` and `wbWR<=WRMem` at the edge. No stall.
- **IDLE, load with RD_LAT>0:**
  - Assert `stall=1`.
  - Register `wbWR<=0` as a bubble.
  - Set `cnt<=RD_LAT` and go to WAIT.
- **WAIT:**
  - Assert `stall=(cnt>1)`.
  - While `cnt>1`: decrement `cnt` and register `wbWR<=0`.
  - When `cnt==1`: register `wbData<=RAM[addr]` and `wbWR<=WRMem`, then return to IDLE.
- **Jump resolution:** `taken = JMem | (JCMem & (NEQMem ? ~zeroIn : zeroIn))`.
  - Registered as `pcTaken` and `pcTarget<=jumpIn` in any cycle where `stall==0`.
  - While `stall==1`, register `pcTaken<=0`.
- **WMMem and RMMem both set:** treated as a store only. No load and no stall.
- **Store combined with a jump:** both take effect in the same cycle.
- **Reset:** `wbWR`, `wbData`, `pcTaken`, `pcTarget` and `outPort` go to 0, state to IDLE, `cnt` to 0. RAM contents are not cleared. Reset during WAIT abandons the load and produces no write-back.

## Timing
- Non-load latency is 1 cycle: inputs sampled at edge k are visible on the outputs after edge k.
- Load latency is RD_LAT+1 edges.
- `stall` is high for exactly RD_LAT consecutive cycles per load.
- A store is visible to a load presented in the next cycle, with no forwarding needed.
- `pcTaken` is high for exactly one cycle per taken jump.

## Configuration
- **`MEM_IO_EN` defined:** address 0xFF (the full 8-bit `acIn`, before masking) is memory-mapped to `outPort`.
  - A store to 0xFF writes `outPort<=rsIn` instead of RAM.
  - A load from 0xFF returns `outPort`, with the same RD_LAT timing.
- **`MEM_IO_EN` undefined:** the `outPort` port is absent. 0xFF is an ordinary address that wraps to `RAM[2^ADDR_BITS-1]`.

## Test plan
- **Store then load (RD_LAT=1):** present WMMem=1, acIn=0x03, rsIn=0x5A, then RMMem=1, WRMem=1, acIn=0x03.
  - `stall` is high for 1 cycle.
  - Next: wbWR=1, wbData=0x5A.
- **Conditional jump:**
  - JCMem=1, NEQMem=1, zeroIn=0, jumpIn=0x3F → pcTaken=1, pcTarget=0x3F for one cycle.
  - The same inputs with zeroIn=1 → pcTaken=0.
- **Pass-through and unconditional jump:** WRMem=1, acIn=0x07 → wbWR=1, wbData=0x07. JMem=1, jumpIn=0x10 → pcTaken=1, pcTarget=0x10.
- **Address wrap (ADDR_BITS=5):** store 0x22 to address 0x21, then load from 0x01 → wbData=0x22.
- **Reset mid-load (RD_LAT=3):** assert reset in the second WAIT cycle.
  - Next cycle: stall=0, wbWR=0, state IDLE.
  - Previously stored RAM data is still readable afterwards.
- **MEM_IO_EN:**
  - Store rsIn=0xA5 to acIn=0xFF → outPort=0xA5, and RAM[0x1F] is unchanged.
  - Without the macro, the same store writes RAM[0x1F].

Source files
------------

// File: rtl/mem_stage.sv
// Memory-access stage: data-RAM loads/stores with RD_LAT wait cycles, jump resolution, write-back register.
// Optional MEM_IO_EN maps full address 0xFF onto the registered outPort.
module mem_stage #(
  parameter int ADDR_BITS = 5,
  parameter int RD_LAT    = 1
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       WRMem,
  input  logic       WMMem,
  input  logic       RMMem,
  input  logic       NEQMem,
  input  logic       JMem,
  input  logic       JCMem,
  input  logic       zeroIn,
  input  logic [7:0] acIn,
  input  logic [7:0] jumpIn,
  input  logic [7:0] rsIn,
  output logic       stall,
  output logic       wbWR,
  output logic [7:0] wbData,
  output logic       pcTaken,
  output logic [7:0] pcTarget
`ifdef MEM_IO_EN
  ,
  output logic [7:0] outPort
`endif
);

  typedef enum logic {IDLE, WAIT} state_t;

  state_t                 r_state, w_state_n;
  logic [2:0]             r_cnt, w_cnt_n;
  logic [7:0]             r_ram [2**ADDR_BITS];
  logic [ADDR_BITS-1:0]   w_addr;
  logic                   w_io_hit;
  logic                   w_is_load;
  logic                   w_store;
  logic                   w_taken;
  logic [7:0]             w_rd_data;
  logic                   w_wb_wr;
  logic [7:0]             w_wb_data;

  assign w_addr    = acIn[ADDR_BITS-1:0];
  // A simultaneous store request wins: the instruction is treated as a store only.
  assign w_is_load = RMMem & ~WMMem;
  assign w_store   = (r_state == IDLE) & WMMem;
  assign w_taken   = JMem | (JCMem & (NEQMem ? ~zeroIn : zeroIn));

`ifdef MEM_IO_EN
  assign w_io_hit  = (acIn == 8'hFF);
  assign w_rd_data = w_io_hit ? outPort : r_ram[w_addr];
`else
  assign w_io_hit  = 1'b0;
  assign w_rd_data = r_ram[w_addr];
`endif

  always_comb begin
    w_state_n = r_state;
    w_cnt_n   = r_cnt;
    stall     = 1'b0;
    w_wb_wr   = WRMem;
    w_wb_data = acIn;
    case (r_state)
      IDLE: begin
        if (w_is_load) begin
          if (RD_LAT == 0) begin
            w_wb_data = w_rd_data;
          end else begin
            stall     = 1'b1;
            w_wb_wr   = 1'b0;
            w_wb_data = wbData;
            w_cnt_n   = 3'(RD_LAT);
            w_state_n = WAIT;
          end
        end
      end
      WAIT: begin
        // Upstream holds the load inputs, so the address is still valid here.
        if (r_cnt > 3'd1) begin
          stall     = 1'b1;
          w_cnt_n   = r_cnt - 3'd1;
          w_wb_wr   = 1'b0;
          w_wb_data = wbData;
        end else begin
          w_wb_data = w_rd_data;
          w_cnt_n   = '0;
          w_state_n = IDLE;
        end
      end
      default: w_state_n = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state  <= IDLE;
      r_cnt    <= '0;
      wbWR     <= 1'b0;
      wbData   <= '0;
      pcTaken  <= 1'b0;
      pcTarget <= '0;
    end else begin
      r_state <= w_state_n;
      r_cnt   <= w_cnt_n;
      wbWR    <= w_wb_wr;
      wbData  <= w_wb_data;
      pcTaken <= w_taken & ~stall;
      if (!stall) pcTarget <= jumpIn;
    end
  end

`ifdef MEM_IO_EN
  always_ff @(posedge clock) begin
    if (reset) outPort <= '0;
    else if (w_store && w_io_hit) outPort <= rsIn;
  end
`endif

  // RAM contents survive reset; writes are simply suppressed while reset is held.
  always_ff @(posedge clock) begin
    if (!reset && w_store && !w_io_hit) r_ram[w_addr] <= rsIn;
  end

endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: RD_LAT=1 and RD_LAT=3 instances, directed plus random instructions
// checked against a per-instruction behavioural model of memory, latency and jumps.
module tb_mem_stage;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic       reset, WRMem, WMMem, RMMem, NEQMem, JMem, JCMem, zeroIn;
  logic [7:0] acIn, jumpIn, rsIn;

  logic       stall1, wbWR1, pcTaken1;
  logic [7:0] wbData1, pcTarget1;
  logic       stall3, wbWR3, pcTaken3;
  logic [7:0] wbData3, pcTarget3;
`ifdef MEM_IO_EN
  logic [7:0] outPort1, outPort3;
`endif

  mem_stage #(.ADDR_BITS(5), .RD_LAT(1)) u_dut1 (
    .clock(clock), .reset(reset), .WRMem(WRMem), .WMMem(WMMem), .RMMem(RMMem),
    .NEQMem(NEQMem), .JMem(JMem), .JCMem(JCMem), .zeroIn(zeroIn), .acIn(acIn),
    .jumpIn(jumpIn), .rsIn(rsIn), .stall(stall1), .wbWR(wbWR1), .wbData(wbData1),
    .pcTaken(pcTaken1), .pcTarget(pcTarget1)
`ifdef MEM_IO_EN
    , .outPort(outPort1)
`endif
  );

  mem_stage #(.ADDR_BITS(5), .RD_LAT(3)) u_dut3 (
    .clock(clock), .reset(reset), .WRMem(WRMem), .WMMem(WMMem), .RMMem(RMMem),
    .NEQMem(NEQMem), .JMem(JMem), .JCMem(JCMem), .zeroIn(zeroIn), .acIn(acIn),
    .jumpIn(jumpIn), .rsIn(rsIn), .stall(stall3), .wbWR(wbWR3), .wbData(wbData3),
    .pcTaken(pcTaken3), .pcTarget(pcTarget3)
`ifdef MEM_IO_EN
    , .outPort(outPort3)
`endif
  );

  int lat = 1;
  int errors = 0;
  int checks = 0;
  logic [7:0] mem_m [32];
  logic [7:0] out_m = 8'h00;

  logic       s_stall, s_wbWR, s_pcTaken;
  logic [7:0] s_wbData, s_pcTarget;
  assign s_stall    = (lat == 1) ? stall1    : stall3;
  assign s_wbWR     = (lat == 1) ? wbWR1     : wbWR3;
  assign s_pcTaken  = (lat == 1) ? pcTaken1  : pcTaken3;
  assign s_wbData   = (lat == 1) ? wbData1   : wbData3;
  assign s_pcTarget = (lat == 1) ? pcTarget1 : pcTarget3;
`ifdef MEM_IO_EN
  logic [7:0] s_outPort;
  assign s_outPort = (lat == 1) ? outPort1 : outPort3;
`endif

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s lat=%0d observed=%0h expected=%0h", tag, lat, got, exp);
    end
  endtask

  task automatic drive(input logic wr, wm, rm, neq, j, jc, z, input logic [7:0] ac, jt, rs);
    WRMem = wr; WMMem = wm; RMMem = rm; NEQMem = neq;
    JMem = j; JCMem = jc; zeroIn = z; acIn = ac; jumpIn = jt; rsIn = rs;
  endtask

  task automatic do_reset();
    drive(0, 0, 0, 0, 0, 0, 0, 8'h00, 8'h00, 8'h00);
    reset = 1'b1;
    @(posedge clock); @(negedge clock);
    reset = 1'b0;
    out_m = 8'h00;
    #1;
    chk("rst_stall", {7'b0, s_stall}, 8'h00);
    chk("rst_wbWR", {7'b0, s_wbWR}, 8'h00);
    chk("rst_wbData", s_wbData, 8'h00);
    chk("rst_pcTaken", {7'b0, s_pcTaken}, 8'h00);
    chk("rst_pcTarget", s_pcTarget, 8'h00);
`ifdef MEM_IO_EN
    chk("rst_outPort", s_outPort, 8'h00);
`endif
  endtask

  // One instruction, held for as many cycles as the stage stalls for it; called just after a negedge.
  task automatic instr(input logic wr, wm, rm, neq, j, jc, z, input logic [7:0] ac, jt, rs);
    logic       ld, tk, io;
    logic [7:0] ldv;
    int         n;
    ld = rm & ~wm;
    tk = j | (jc & (neq ? ~z : z));
    io = 1'b0;
`ifdef MEM_IO_EN
    io = (ac == 8'hFF);
`endif
    ldv = io ? out_m : mem_m[ac[4:0]];
    n = ld ? lat : 0;
    drive(wr, wm, rm, neq, j, jc, z, ac, jt, rs);
    for (int c = 0; c <= n; c++) begin
      #1;
      chk("stall", {7'b0, s_stall}, {7'b0, (c < n)});
      @(posedge clock); @(negedge clock);
      if (c < n) begin
        chk("bubble_wbWR", {7'b0, s_wbWR}, 8'h00);
        chk("bubble_pcTaken", {7'b0, s_pcTaken}, 8'h00);
      end else begin
        chk("wbWR", {7'b0, s_wbWR}, {7'b0, wr});
        chk("wbData", s_wbData, ld ? ldv : ac);
        chk("pcTaken", {7'b0, s_pcTaken}, {7'b0, tk});
        chk("pcTarget", s_pcTarget, jt);
      end
    end
    if (wm) begin
      if (io) out_m = rs;
      else mem_m[ac[4:0]] = rs;
    end
`ifdef MEM_IO_EN
    chk("outPort", s_outPort, out_m);
`endif
  endtask

  task automatic fill_mem();
    for (int a = 0; a < 32; a++) instr(0, 1, 0, 0, 0, 0, 0, 8'(a), 8'h00, 8'($urandom));
  endtask

  task automatic random_run(input int count);
    for (int k = 0; k < count; k++) begin
      logic [7:0] ac;
      ac = ($urandom % 5 == 0) ? 8'hFF : 8'($urandom);
      instr(1'($urandom), ($urandom % 4 == 0), ($urandom % 3 == 0), 1'($urandom),
            ($urandom % 5 == 0), ($urandom % 3 == 0), 1'($urandom), ac,
            8'($urandom), 8'($urandom));
    end
  endtask

  initial begin
    reset = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 8'h00, 8'h00, 8'h00);
    @(negedge clock);

    // RD_LAT = 1
    lat = 1;
    do_reset();
    fill_mem();
    instr(0, 1, 0, 0, 0, 0, 0, 8'h03, 8'h00, 8'h5A);
    instr(1, 0, 1, 0, 0, 0, 0, 8'h03, 8'h00, 8'h00);
    chk("store_load_data", s_wbData, 8'h5A);
    instr(0, 0, 0, 1, 0, 1, 0, 8'h00, 8'h3F, 8'h00);
    instr(0, 0, 0, 1, 0, 1, 1, 8'h00, 8'h3F, 8'h00);
    instr(1, 0, 0, 0, 0, 0, 0, 8'h07, 8'h00, 8'h00);
    instr(0, 0, 0, 0, 1, 0, 0, 8'h00, 8'h10, 8'h00);
    instr(0, 0, 0, 0, 1, 0, 0, 8'h00, 8'h11, 8'h00);
    instr(0, 0, 0, 0, 0, 1, 1, 8'h00, 8'h22, 8'h00);
    instr(0, 1, 0, 0, 0, 0, 0, 8'h21, 8'h00, 8'h22);
    instr(1, 0, 1, 0, 0, 0, 0, 8'h01, 8'h00, 8'h00);
    instr(1, 1, 1, 0, 1, 0, 0, 8'h04, 8'h44, 8'h99);
    instr(1, 0, 1, 0, 0, 0, 0, 8'h04, 8'h00, 8'h00);
    instr(0, 1, 0, 0, 0, 0, 0, 8'hFF, 8'h00, 8'hA5);
    instr(1, 0, 1, 0, 0, 0, 0, 8'h1F, 8'h00, 8'h00);
    instr(1, 0, 1, 0, 0, 0, 0, 8'hFF, 8'h00, 8'h00);
    random_run(60);

    // RD_LAT = 3
    lat = 3;
    do_reset();
    fill_mem();
    instr(0, 1, 0, 0, 0, 0, 0, 8'h05, 8'h00, 8'hC3);
    instr(1, 0, 1, 0, 1, 0, 0, 8'h05, 8'h66, 8'h00);
    drive(1, 0, 1, 0, 0, 0, 0, 8'h05, 8'h00, 8'h00);
    @(posedge clock); @(negedge clock);
    @(posedge clock); @(negedge clock);
    reset = 1'b1;
    @(posedge clock); @(negedge clock);
    reset = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 8'h00, 8'h00, 8'h00);
    out_m = 8'h00;
    #1;
    chk("midload_stall", {7'b0, s_stall}, 8'h00);
    chk("midload_wbWR", {7'b0, s_wbWR}, 8'h00);
    chk("midload_wbData", s_wbData, 8'h00);
    @(posedge clock); @(negedge clock);
    chk("after_rst_wbWR", {7'b0, s_wbWR}, 8'h00);
    instr(1, 0, 1, 0, 0, 0, 0, 8'h05, 8'h00, 8'h00);
    chk("ram_kept", s_wbData, 8'hC3);
    instr(0, 0, 0, 0, 0, 1, 1, 8'h00, 8'h3C, 8'h00);
    random_run(60);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
